lbp_hist: RTL and testbench
===========================

// Module: lbp_hist
// PURPOSE
//  Downstream of the LBP engine: accumulates its 8-bit LBP codes into a histogram (one counter per bin).
//  After the engine's finish, streams the bins out under valid/ready for the feature/classifier stage.
//  Sits between the LBP engine outputs (lbp_valid/lbp_data/finish) and the feature consumer.
// PARAMETERS
//  CNT_W   14   bin counter width; bins saturate at 2^CNT_W-1 (126*126=15876 pixels fit)
//  NBIN    256  bins in full mode; forced to 59 when LBP_HIST_UNIFORM_EN is defined
// PORTS
//  clk          in   1      single clock, rising edge
//  reset        in   1      synchronous, active-high
//  lbp_valid    in   1      LBP code strobe; one code per high cycle, no backpressure
//  lbp_data     in   8      LBP code
//  lbp_finish   in   1      LBP engine done; level, held high until reset
//  hist_busy    out  1      high while bin RAM is being cleared
//  hist_valid   out  1      readout data valid
//  hist_ready   in   1      readout consumer ready
//  hist_bin     out  8      bin index of current readout word
//  hist_count   out  CNT_W  count of that bin
//  hist_last    out  1      high with the final bin (NBIN-1)
//  hist_done    out  1      readout complete; held until reset
//  pix_total    out  14     codes accepted, saturating at 16383
//  drop_err     out  1      sticky: lbp_valid seen while not in ACCUM
// BEHAVIOUR
//  Reset (sync, active-high): all outputs 0 except hist_busy=1; FSM->CLEAR; mid-operation reset aborts any phase.
//  FSM: CLEAR -> ACCUM -> DRAIN -> READOUT -> DONE.
//   CLEAR: writes 0 to bins 0..NBIN-1, one per cycle; exactly NBIN cycles; then ACCUM, hist_busy=0.
//   ACCUM: each lbp_valid does bin[idx]++ (saturating at 2^CNT_W-1) and pix_total++; on lbp_finish -> DRAIN.
//    lbp_valid in the same cycle as lbp_finish's rise is still counted.
//   DRAIN: wait until the RMW pipeline is empty (<=2 cycles), then READOUT.
//   READOUT: bins presented in order 0..NBIN-1; word transfers when hist_valid&&hist_ready;
//    hist_bin/hist_count stable while hist_valid&&!hist_ready; 1 bin/cycle with hist_ready held high;
//    first hist_valid <=4 cycles after lbp_finish rises; after transfer with hist_last -> DONE.
//   DONE: hist_valid=0, hist_done=1; inputs ignored except drop_err update.
//  RMW pipeline: sync-read RAM; stage1 read, stage2 add+write. Back-to-back codes to the same bin
//   (consecutive or one cycle apart) are forwarded from the write stage, so no increment is lost.
//  drop_err: set by lbp_valid in CLEAR, DRAIN, READOUT or DONE; code discarded; cleared only by reset.
//  Widths: hist_count zero-extended; hist_bin upper bits 0 in uniform mode.
// CONFIGURATION
//  LBP_HIST_UNIFORM_EN defined: code mapped to 59 bins: uniform codes (<=2 circular 0/1 transitions,
//   58 of them) get index 0..57 in ascending code value; all other codes -> bin 58. NBIN=59, readout 59 words.
//  Undefined: bin index = lbp_data directly, NBIN=256, readout 256 words.
// STRUCTURE
//  Package lbp_hist_pkg: state enum, CNT_W default, NBIN_FULL=256, NBIN_UNI=59,
//   function uni_idx(code) giving the uniform-mode bin map (constant LUT).
//  Sub-module lbp_hist_ram: NBIN x CNT_W, 1 write + 1 sync-read port, read-during-write returns old data.
//  Top holds FSM, clear counter, RMW pipeline with forwarding, readout skid register.
// TESTING
//  Reset, wait: hist_busy high exactly 256 cycles (59 uniform), all outputs else 0.
//  15876 codes, all 8'h00 back-to-back, then finish -> bin0=15876, all others 0, pix_total=15876.
//  Codes 5,5,7,5 with gaps of 0 and 1 cycles -> bin5=3, bin7=1 (forwarding check).
//  2^CNT_W+3 codes of 8'hFF -> bin255=16383 (saturated), no wrap.
//  Readout with hist_ready toggled 1,0,0,1 -> no bin lost/duplicated; hist_last only on bin 255; hist_done after.
//  lbp_valid during CLEAR -> drop_err=1, code not counted; reset during READOUT -> back to CLEAR, outputs reset.
//  UNIFORM_EN: codes 8'h00,8'h01,8'h05 -> bins 0,1,58 each count 1; readout 59 words.

Source files
------------

// File: rtl/lbp_hist_pkg.sv
// Shared types, widths and the uniform-pattern bin map for the LBP histogram block.
package lbp_hist_pkg;

  localparam int unsigned CNT_W     = 14;
  localparam int unsigned PIX_W     = 14;
  localparam int unsigned BIN_W     = 8;
  localparam int unsigned NBIN_FULL = 256;
  localparam int unsigned NBIN_UNI  = 59;

  typedef enum logic [2:0] {
    S_CLEAR,
    S_ACCUM,
    S_DRAIN,
    S_READOUT,
    S_DONE
  } state_t;

  typedef struct packed {
    logic [BIN_W-1:0] bin;
    logic [CNT_W-1:0] cnt;
    logic             last;
  } hist_word_t;

  // Uniform pattern: at most two 0/1 transitions around the circular code.
  function automatic logic is_uniform(input logic [7:0] code);
    return ($countones(code ^ {code[0], code[7:1]}) <= 2);
  endfunction

  // Uniform codes ranked by value into 0..57; every other code lands in bin 58.
  function automatic logic [7:0] uni_idx(input logic [7:0] code);
    logic [7:0] rank;
    rank = 8'd0;
    for (int c = 0; c < 256; c++) begin
      if ((8'(c) < code) && is_uniform(8'(c))) rank = rank + 8'd1;
    end
    return is_uniform(code) ? rank : 8'd58;
  endfunction

endpackage

// File: rtl/lbp_hist_ram.sv
// Bin storage: one write port, one registered read port; a read colliding with a write returns old data.
module lbp_hist_ram #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned W     = 14,
  parameter int unsigned AW    = 8
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);

  logic [W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/lbp_hist.sv
// LBP code histogram: clear bins, accumulate codes via a forwarded RMW pipeline, stream bins out.
// Define LBP_HIST_UNIFORM_EN to fold codes into 59 uniform-pattern bins instead of 256.
module lbp_hist
  import lbp_hist_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             lbp_valid,
  input  logic [7:0]       lbp_data,
  input  logic             lbp_finish,
  output logic             hist_busy,
  output logic             hist_valid,
  input  logic             hist_ready,
  output logic [7:0]       hist_bin,
  output logic [CNT_W-1:0] hist_count,
  output logic             hist_last,
  output logic             hist_done,
  output logic [PIX_W-1:0] pix_total,
  output logic             drop_err
);

`ifdef LBP_HIST_UNIFORM_EN
  localparam bit UNIFORM = 1'b1;
`else
  localparam bit UNIFORM = 1'b0;
`endif

  localparam int unsigned      NBIN     = UNIFORM ? NBIN_UNI : NBIN_FULL;
  localparam int unsigned      AW       = $clog2(NBIN);
  localparam int unsigned      RAW      = AW + 1;
  localparam logic [AW-1:0]    LAST_IDX = AW'(NBIN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [PIX_W-1:0] PIX_MAX  = '1;

  state_t           r_state, w_next;
  logic             w_clr_en, w_acc, w_rd_phase, w_drop;

  logic [AW-1:0]    r_clr_cnt;
  logic [AW-1:0]    w_idx;
  logic             r_s1_v, r_s2_v;
  logic [AW-1:0]    r_s1_idx, r_s2_idx;
  logic [CNT_W-1:0] r_s2_cnt, w_opnd, w_sum, w_rdata;

  logic             w_we;
  logic [AW-1:0]    w_waddr, w_raddr;
  logic [CNT_W-1:0] w_wdata;

  logic [RAW-1:0]   r_ra;
  logic             r_rv;
  logic [AW-1:0]    r_ridx;
  hist_word_t       r_out, r_skid, w_rword;
  logic             r_out_v, r_skid_v, w_xfer, w_issue;
  logic [1:0]       w_occ;

  logic             r_busy, r_done, r_drop;
  logic [PIX_W-1:0] r_pix;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_CLEAR;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_CLEAR:   if (r_clr_cnt == LAST_IDX) w_next = S_ACCUM;
      S_ACCUM:   if (lbp_finish) w_next = S_DRAIN;
      // The last accepted code retires its write during this cycle.
      S_DRAIN:   w_next = S_READOUT;
      S_READOUT: if (w_xfer && r_out.last) w_next = S_DONE;
      S_DONE:    w_next = S_DONE;
      default:   w_next = S_CLEAR;
    endcase
  end

  always_comb begin
    w_clr_en   = 1'b0;
    w_acc      = 1'b0;
    w_rd_phase = 1'b0;
    w_drop     = 1'b0;
    case (r_state)
      S_CLEAR:   begin w_clr_en = 1'b1; w_drop = lbp_valid; end
      S_ACCUM:   w_acc = lbp_valid;
      S_READOUT: begin w_rd_phase = 1'b1; w_drop = lbp_valid; end
      default:   w_drop = lbp_valid;
    endcase
  end

  assign w_idx = UNIFORM ? AW'(uni_idx(lbp_data)) : AW'(lbp_data);

  // Forward the previous write when it targets the bin being updated now.
  always_comb begin
    w_opnd  = (r_s2_v && (r_s2_idx == r_s1_idx)) ? r_s2_cnt : w_rdata;
    w_sum   = (w_opnd == CNT_MAX) ? w_opnd : w_opnd + CNT_W'(1);
    w_we    = w_clr_en | r_s1_v;
    w_waddr = w_clr_en ? r_clr_cnt : r_s1_idx;
    w_wdata = w_clr_en ? '0 : w_sum;
    w_raddr = w_rd_phase ? r_ra[AW-1:0] : w_idx;
  end

  lbp_hist_ram #(
    .DEPTH (NBIN),
    .W     (CNT_W),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  // Reads are issued only when the output and skid registers can absorb the returning word.
  always_comb begin
    w_xfer        = r_out_v && hist_ready;
    w_occ         = 2'(r_out_v) + 2'(r_skid_v) + 2'(r_rv) - 2'(w_xfer);
    w_issue       = w_rd_phase && (r_ra < RAW'(NBIN)) && (w_occ <= 2'd1);
    w_rword.bin   = BIN_W'(r_ridx);
    w_rword.cnt   = w_rdata;
    w_rword.last  = (r_ridx == LAST_IDX);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_clr_cnt <= '0;
      r_s1_v    <= 1'b0;
      r_s1_idx  <= '0;
      r_s2_v    <= 1'b0;
      r_s2_idx  <= '0;
      r_s2_cnt  <= '0;
    end else begin
      if (w_clr_en) r_clr_cnt <= r_clr_cnt + AW'(1);
      r_s1_v   <= w_acc;
      r_s1_idx <= w_idx;
      r_s2_v   <= r_s1_v;
      r_s2_idx <= r_s1_idx;
      r_s2_cnt <= w_sum;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ra     <= '0;
      r_rv     <= 1'b0;
      r_ridx   <= '0;
      r_out_v  <= 1'b0;
      r_out    <= '0;
      r_skid_v <= 1'b0;
      r_skid   <= '0;
    end else begin
      r_rv <= w_issue;
      if (w_issue) begin
        r_ra   <= r_ra + RAW'(1);
        r_ridx <= r_ra[AW-1:0];
      end
      if (!r_out_v || w_xfer) begin
        if (r_skid_v) begin
          r_out    <= r_skid;
          r_out_v  <= 1'b1;
          r_skid_v <= r_rv;
          r_skid   <= w_rword;
        end else begin
          r_out_v <= r_rv;
          r_out   <= r_rv ? w_rword : '0;
        end
      end else if (r_rv) begin
        r_skid_v <= 1'b1;
        r_skid   <= w_rword;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy <= 1'b1;
      r_done <= 1'b0;
      r_drop <= 1'b0;
      r_pix  <= '0;
    end else begin
      r_busy <= (w_next == S_CLEAR);
      r_done <= (w_next == S_DONE);
      r_drop <= r_drop | w_drop;
      if (w_acc && (r_pix != PIX_MAX)) r_pix <= r_pix + PIX_W'(1);
    end
  end

  assign hist_busy  = r_busy;
  assign hist_valid = r_out_v;
  assign hist_bin   = r_out.bin;
  assign hist_count = r_out.cnt;
  assign hist_last  = r_out.last;
  assign hist_done  = r_done;
  assign pix_total  = r_pix;
  assign drop_err   = r_drop;

endmodule

// File: tb/tb_lbp_hist.sv
// Randomized scoreboard bench for lbp_hist against a bin-array reference model.
module tb_lbp_hist;
  import lbp_hist_pkg::*;

`ifdef LBP_HIST_UNIFORM_EN
  localparam int NB  = 59;
  localparam bit UNI = 1'b1;
`else
  localparam int NB  = 256;
  localparam bit UNI = 1'b0;
`endif
  localparam int SAT = 16383;

  logic             clk;
  logic             reset, lbp_valid, lbp_finish, hist_ready;
  logic [7:0]       lbp_data;
  logic             hist_busy, hist_valid, hist_last, hist_done, drop_err;
  logic [7:0]       hist_bin;
  logic [CNT_W-1:0] hist_count;
  logic [13:0]      pix_total;

  lbp_hist dut (
    .clk        (clk),
    .reset      (reset),
    .lbp_valid  (lbp_valid),
    .lbp_data   (lbp_data),
    .lbp_finish (lbp_finish),
    .hist_busy  (hist_busy),
    .hist_valid (hist_valid),
    .hist_ready (hist_ready),
    .hist_bin   (hist_bin),
    .hist_count (hist_count),
    .hist_last  (hist_last),
    .hist_done  (hist_done),
    .pix_total  (pix_total),
    .drop_err   (drop_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int bin;
    int cnt;
    bit last;
  } exp_t;

  int   total, bad;
  int   ref_cnt [256];
  int   ref_pix;
  int   uni_map [256];
  exp_t sb [$];
  bit   sb_en;
  int   rdy_mode;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void model_add(input logic [7:0] c);
    int b;
    b = UNI ? uni_map[c] : int'(c);
    if (ref_cnt[b] < SAT) ref_cnt[b]++;
    if (ref_pix < SAT) ref_pix++;
  endfunction

  // Ready pattern: 0 = always ready, 1 = repeating 1,0,0,1, else random.
  initial begin
    int k;
    k = 0;
    hist_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: hist_ready = 1'b1;
        1: begin hist_ready = ((k % 4) == 0) || ((k % 4) == 3); k++; end
        default: hist_ready = ($urandom_range(0, 2) != 0);
      endcase
    end
  end

  // Monitor: pops an expected word on every transfer and checks stall stability.
  initial begin
    exp_t e;
    logic [7:0] st_bin;
    logic [CNT_W-1:0] st_cnt;
    bit st_pend;
    st_pend = 1'b0;
    st_bin = '0;
    st_cnt = '0;
    forever begin
      @(negedge clk);
      if (reset || !sb_en) st_pend = 1'b0;
      else if (hist_valid) begin
        if (st_pend) begin
          check("stall_bin", hist_bin, st_bin);
          check("stall_cnt", hist_count, st_cnt);
        end
        if (hist_ready) begin
          if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL extra_word: bin %0d arrived with nothing expected", hist_bin);
          end else begin
            e = sb.pop_front();
            check("rd_bin", hist_bin, e.bin);
            check("rd_cnt", hist_count, e.cnt);
            check("rd_last", hist_last, e.last);
          end
          st_pend = 1'b0;
        end else begin
          st_pend = 1'b1;
          st_bin  = hist_bin;
          st_cnt  = hist_count;
        end
      end
    end
  end

  task automatic do_reset(input bit inject_clear);
    int n;
    @(negedge clk); #1;
    reset = 1'b1; lbp_valid = 1'b0; lbp_finish = 1'b0;
    sb_en = 1'b0; sb.delete();
    repeat (3) begin @(negedge clk); #1; end
    check("rst_busy", hist_busy, 1);
    check("rst_valid", hist_valid, 0);
    check("rst_done", hist_done, 0);
    check("rst_pix", pix_total, 0);
    check("rst_drop", drop_err, 0);
    check("rst_last", hist_last, 0);
    check("rst_bin", hist_bin, 0);
    check("rst_count", hist_count, 0);
    for (int b = 0; b < 256; b++) ref_cnt[b] = 0;
    ref_pix = 0;
    reset = 1'b0;
    n = 0;
    while (hist_busy && n < 1000) begin
      lbp_valid = inject_clear && (n == 10);
      lbp_data  = 8'h33;
      n++;
      @(negedge clk); #1;
    end
    lbp_valid = 1'b0;
    check("busy_cycles", n, NB);
  endtask

  task automatic send(input logic [7:0] c, input int gap);
    lbp_valid = 1'b1; lbp_data = c;
    model_add(c);
    @(negedge clk); #1;
    lbp_valid = 1'b0;
    repeat (gap) begin @(negedge clk); #1; end
  endtask

  task automatic finish_start(input bit with_code, input logic [7:0] code);
    exp_t e;
    int n;
    lbp_finish = 1'b1;
    if (with_code) begin
      lbp_valid = 1'b1; lbp_data = code;
      model_add(code);
    end
    for (int b = 0; b < NB; b++) begin
      e.bin = b; e.cnt = ref_cnt[b]; e.last = (b == NB - 1);
      sb.push_back(e);
    end
    sb_en = 1'b1;
    n = 0;
    do begin
      @(negedge clk); #1;
      lbp_valid = 1'b0;
      n++;
    end while (!hist_valid && n < 20);
    total++;
    if (n > 4) begin
      bad++;
      $display("FAIL first_valid_latency: %0d cycles after finish, limit 4", n);
    end
  endtask

  task automatic wait_done(input bit exp_drop);
    int n;
    n = 0;
    while (!hist_done && n < 5000) begin @(negedge clk); #1; n++; end
    check("done_reached", hist_done, 1);
    repeat (2) begin @(negedge clk); #1; end
    check("sb_drained", sb.size(), 0);
    check("valid_after_done", hist_valid, 0);
    check("pix_total", pix_total, ref_pix);
    check("drop_err", drop_err, exp_drop);
  endtask

  initial begin
    logic [7:0] c;
    int k, tr, n;
    total = 0; bad = 0;
    reset = 1'b1; lbp_valid = 1'b0; lbp_data = '0; lbp_finish = 1'b0;
    sb_en = 1'b0; rdy_mode = 0; ref_pix = 0;

    k = 0;
    for (int v = 0; v < 256; v++) begin
      tr = 0;
      for (int b = 0; b < 8; b++)
        if (((v >> b) & 1) != ((v >> ((b + 1) % 8)) & 1)) tr++;
      if (tr <= 2) begin uni_map[v] = k; k++; end
      else uni_map[v] = 58;
    end

    // Run A: drop during clear, forwarding pattern, random hazards, toggled ready.
    do_reset(1'b1);
    check("drop_in_clear", drop_err, 1);
    rdy_mode = 1;
    send(8'h05, 0); send(8'h05, 1); send(8'h07, 0); send(8'h05, 1);
    send(8'h00, 0); send(8'h01, 0);
    repeat (400) begin
      c = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'(5 + $urandom_range(0, 3));
      send(c, $urandom_range(0, 2));
    end
    finish_start(1'b1, 8'h05);
    wait_done(1'b1);
    n = ref_pix;
    lbp_valid = 1'b1; lbp_data = 8'h05;
    @(negedge clk); #1;
    lbp_valid = 1'b0;
    @(negedge clk); #1;
    check("done_ignores_pix", pix_total, n);
    check("done_held", hist_done, 1);
    check("done_no_valid", hist_valid, 0);

    // Run B: a full 126x126 frame of zero codes.
    do_reset(1'b0);
    rdy_mode = 0;
    repeat (15876) send(8'h00, 0);
    finish_start(1'b0, 8'h00);
    wait_done(1'b0);

    // Run C: bin saturation with more codes than the counter holds.
    do_reset(1'b0);
    rdy_mode = 2;
    repeat (16387) send(8'hFF, 0);
    finish_start(1'b0, 8'h00);
    wait_done(1'b0);

    // Run D: reset in the middle of readout, then a short run on freshly cleared bins.
    do_reset(1'b0);
    repeat (30) send(8'($urandom_range(0, 255)), $urandom_range(0, 1));
    finish_start(1'b0, 8'h00);
    n = 0;
    while (sb.size() > NB - 6 && n < 2000) begin @(negedge clk); #1; n++; end
    check("partial_readout", (sb.size() <= NB - 6) ? 1 : 0, 1);
    do_reset(1'b0);
    rdy_mode = 1;
    send(8'h00, 0); send(8'h01, 1); send(8'h05, 0);
    finish_start(1'b0, 8'h00);
    wait_done(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
